multi_counter_dumper: RTL

//  Initiator/consumer for the multi_counter command/status interfaces.
//  - On start, sweeps all counter ids 0..CNTRS_N-1 with query commands, inserted into idle command slots.
//  - Captures the matching status responses into a small FIFO and presents them as a valid/ready stream.
//  - Sits between the upstream command source and multi_counter; upstream commands pass through with priority.

---
 rtl/multi_counter_pkg.sv | 22 ++
 rtl/multi_counter_dump_fifo.sv | 55 +++++
 rtl/multi_counter_dumper.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/multi_counter_pkg.sv
// Shared command encoding for multi_counter and the state encoding of its dumper.
package multi_counter_pkg;

  localparam int OP_WRITE_B  = 0;
  localparam int OP_READ_B   = 1;
  localparam int OP_OUTPUT_B = 2;

  typedef logic [2:0] op_t;

  localparam op_t OP_NOP  = 3'b000;
  localparam op_t OP_INIT = 3'b001;
  localparam op_t OP_INCR = 3'b011;
  // A query reads and reports the counter without modifying it.
  localparam op_t OP_QRY  = 3'b110;

  typedef logic [1:0] dump_state_t;

  localparam dump_state_t IDLE  = 2'd0;
  localparam dump_state_t ISSUE = 2'd1;
  localparam dump_state_t DRAIN = 2'd2;

endpackage

// File: rtl/multi_counter_dump_fifo.sv
// Synchronous result FIFO for the counter dumper, exposing its fill count.
module multi_counter_dump_fifo #(
  parameter int W     = 35,
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     pop_dat,
  output logic             empty,
  output logic [CNT_W-1:0] cnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]     mem [N];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(N));
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // The dumper's credit check reserves a slot for every query in flight.
  assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/multi_counter_dumper.sv
// Sweeps every counter with query commands slotted into idle command cycles
// and streams the returned values out through a small result FIFO.
module multi_counter_dumper
  import multi_counter_pkg::*;
#(
  parameter int CNTRS_N    = 256,
  parameter int CNTRS_W    = 32,
  parameter int CNTRS_ID_W = $clog2(CNTRS_N),
  parameter int LAT        = 4,
  parameter int FIFO_N     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_pass,
  input  logic [CNTRS_ID_W-1:0] in_id,
  input  op_t                   in_op,
  input  logic [CNTRS_W-1:0]    in_dat,
  output logic                  cntr_pass,
  output logic [CNTRS_ID_W-1:0] cntr_id,
  output op_t                   cntr_op,
  output logic [CNTRS_W-1:0]    cntr_dat,
  input  logic                  status_pass_r,
  input  logic                  status_qry_r,
  input  logic [CNTRS_ID_W-1:0] status_id_r,
  input  logic [CNTRS_W-1:0]    status_dat_r,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  dump_vld,
  input  logic                  dump_rdy,
  output logic [CNTRS_ID_W-1:0] dump_id,
  output logic [CNTRS_W-1:0]    dump_dat
);

  localparam int CNT_W = $clog2(FIFO_N + 1);
  localparam logic [CNTRS_ID_W-1:0] LAST_ID = CNTRS_ID_W'(CNTRS_N - 1);

  dump_state_t                      state;
  logic [CNTRS_ID_W-1:0]            ptr;
  logic [LAT-1:0]                   tag_vld;
  logic [CNTRS_ID_W-1:0]            tag_id [LAT];
  logic [CNT_W-1:0]                 fifo_cnt;
  logic                             fifo_empty;
  logic                             fifo_push;
  logic                             fifo_pop;
  logic [CNTRS_ID_W+CNTRS_W-1:0]    fifo_rd;
  logic                             issue_en;
  logic                             capture_bad;

  // Credit ignores a same-cycle pop so the FIFO can never be overrun.
  assign issue_en = (state == ISSUE) && !in_pass &&
                    (($countones(tag_vld) + int'(fifo_cnt)) < FIFO_N);

  always_comb begin
    cntr_pass = 1'b0;
    cntr_id   = in_id;
    cntr_op   = in_op;
    cntr_dat  = in_dat;
    if (in_pass) begin
      cntr_pass = 1'b1;
    end else if (issue_en) begin
      cntr_pass = 1'b1;
      cntr_id   = ptr;
      cntr_op   = OP_QRY;
      cntr_dat  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tag_vld <= '0;
    else     tag_vld <= {tag_vld[LAT-2:0], issue_en};
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= ptr;
    for (int i = 1; i < LAT; i++) tag_id[i] <= tag_id[i-1];
  end

  // A tag leaving the pipe lines up with the status of its own query.
  assign fifo_push   = tag_vld[LAT-1];
  assign capture_bad = !status_pass_r || !status_qry_r ||
                       (status_id_r != tag_id[LAT-1]);

  always_ff @(posedge clk) begin
    if (rst)                           err <= 1'b0;
    else if (fifo_push && capture_bad) err <= 1'b1;
  end

  assign dump_vld = !fifo_empty;
  assign fifo_pop = dump_vld && dump_rdy;
  assign {dump_id, dump_dat} = fifo_rd;
  assign busy = (state != IDLE);
  assign done = (state == DRAIN) && (tag_vld == '0) && fifo_pop &&
                (fifo_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            ptr   <= '0;
          end
        end
        ISSUE: begin
          if (issue_en) begin
            if (ptr == LAST_ID) begin
              ptr   <= '0;
              state <= DRAIN;
            end else begin
              ptr <= ptr + CNTRS_ID_W'(1);
            end
          end
        end
        DRAIN: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  multi_counter_dump_fifo #(
    .W     (CNTRS_ID_W + CNTRS_W),
    .N     (FIFO_N),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat ({status_id_r, status_dat_r}),
    .pop      (fifo_pop),
    .pop_dat  (fifo_rd),
    .empty    (fifo_empty),
    .cnt      (fifo_cnt)
  );

endmodule
